key_filter_multi: RTL and testbench

- Parametrised N-channel key debouncer, successor to the single-key filter.
- Each channel is an independent 4-state FSM. It emits one-cycle press and release pulses, a stable debounced level and, optionally, a long-press pulse.
- A shared encoder reports the lowest-index channel pressed this cycle.
- Sits between raw board keys and the control logic; keys are active-low, 1 = released.

---
 rtl/key_filter_multi.sv | 215 +++++++++++++++++++++
 tb/tb_key_filter_multi.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/key_filter_multi.sv
// N-channel key debouncer: two-flop synchroniser, per-channel debounce FSM, lowest-index press encoder.
// Define KEY_LONG_PRESS_EN to build the per-channel long-press counter and long pulse output.
module key_filter_multi #(
  parameter int unsigned N      = 4,
  parameter int unsigned MAX    = 100,
  parameter int unsigned CNT_W  = 20,
  parameter int unsigned LONG   = 500000,
  parameter int unsigned LCNT_W = 24,
  parameter int unsigned CODE_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N-1:0]      in,
  output logic [N-1:0]      press,
  output logic [N-1:0]      rel,
  output logic [N-1:0]      level,
  output logic [N-1:0]      long,
  output logic              valid,
  output logic [CODE_W-1:0] code
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX - 1);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    PRESS_DB   = 2'd1,
    PRESSED    = 2'd2,
    RELEASE_DB = 2'd3
  } state_t;

  // Elaboration-time parameter sanity
  if (N < 1 || N > 32) begin : g_bad_n
    $error("key_filter_multi: N must be in 1..32");
  end
  if (MAX < 2) begin : g_bad_max
    $error("key_filter_multi: MAX must be >= 2");
  end
  if (CNT_W < 1 || (CNT_W < 32 && (MAX - 1) >= (32'd1 << CNT_W))) begin : g_bad_cnt_w
    $error("key_filter_multi: CNT_W too narrow for MAX");
  end
  if (LONG < 1 || LCNT_W < 1 || (LCNT_W < 32 && LONG >= (32'd1 << LCNT_W))) begin : g_bad_long
    $error("key_filter_multi: LCNT_W too narrow for LONG");
  end
  if (CODE_W < 1 || (CODE_W < 32 && N > (32'd1 << CODE_W))) begin : g_bad_code_w
    $error("key_filter_multi: CODE_W too narrow for N");
  end

  logic [N-1:0] r0;
  logic [N-1:0] r1;
  logic [N-1:0] press_d;
  logic [N-1:0] rel_d;
  logic [N-1:0] level_d;
  logic [CODE_W-1:0] code_d;

  // Two-flop synchroniser; reset to the released level so nothing looks pressed.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r0 <= '1;
      r1 <= '1;
    end else begin
      r0 <= in;
      r1 <= r0;
    end
  end

  for (genvar g = 0; g < int'(N); g++) begin : g_ch
    state_t           state;
    state_t           state_n;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_n;
    logic             press_c;
    logic             rel_c;
    logic             level_c;

    always_ff @(posedge clk) begin
      if (!rst) begin
        state <= IDLE;
        cnt   <= '0;
      end else begin
        state <= state_n;
        cnt   <= cnt_n;
      end
    end

    // Next state: a level must hold for MAX samples inside a debounce state to be accepted.
    always_comb begin
      state_n = state;
      cnt_n   = cnt;
      case (state)
        IDLE: begin
          if (!r1[g]) begin
            state_n = PRESS_DB;
            cnt_n   = '0;
          end
        end
        PRESS_DB: begin
          if (r1[g]) begin
            state_n = IDLE;
            cnt_n   = '0;
          end else if (cnt == CNT_LAST) begin
            state_n = PRESSED;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt + CNT_W'(1);
          end
        end
        PRESSED: begin
          if (r1[g]) begin
            state_n = RELEASE_DB;
            cnt_n   = '0;
          end
        end
        RELEASE_DB: begin
          if (!r1[g]) begin
            state_n = PRESSED;
            cnt_n   = '0;
          end else if (cnt == CNT_LAST) begin
            state_n = IDLE;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt + CNT_W'(1);
          end
        end
        default: begin
          state_n = IDLE;
          cnt_n   = '0;
        end
      endcase
    end

    // Pulses mark completed debounce transitions; level follows the accepted state.
    always_comb begin
      press_c = 1'b0;
      rel_c   = 1'b0;
      level_c = 1'b0;
      if (state == PRESS_DB && state_n == PRESSED) press_c = 1'b1;
      if (state == RELEASE_DB && state_n == IDLE) rel_c = 1'b1;
      if (state_n == PRESSED || state_n == RELEASE_DB) level_c = 1'b1;
    end

    assign press_d[g] = press_c;
    assign rel_d[g]   = rel_c;
    assign level_d[g] = level_c;
  end

  // Lowest-index press wins the code.
  always_comb begin
    logic found;
    found  = 1'b0;
    code_d = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (press_d[i] && !found) begin
        code_d = CODE_W'(i);
        found  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      press <= '0;
      rel   <= '0;
      level <= '0;
      valid <= 1'b0;
      code  <= '0;
    end else begin
      press <= press_d;
      rel   <= rel_d;
      level <= level_d;
      valid <= |press_d;
      code  <= code_d;
    end
  end

`ifdef KEY_LONG_PRESS_EN
  localparam logic [LCNT_W-1:0] LCNT_MAX  = LCNT_W'(LONG);
  localparam logic [LCNT_W-1:0] LCNT_LAST = LCNT_W'(LONG - 1);

  logic [N-1:0] long_d;

  for (genvar g = 0; g < int'(N); g++) begin : g_long
    logic [LCNT_W-1:0] lcnt;
    logic [LCNT_W-1:0] lcnt_n;
    logic              long_c;

    always_ff @(posedge clk) begin
      if (!rst) lcnt <= '0;
      else      lcnt <= lcnt_n;
    end

    // Hold time counts through release bounces and saturates, so the pulse fires once per press.
    always_comb begin
      lcnt_n = lcnt;
      long_c = 1'b0;
      if (g_ch[g].state == PRESS_DB && g_ch[g].state_n == PRESSED) begin
        lcnt_n = '0;
      end else if ((g_ch[g].state == PRESSED || g_ch[g].state == RELEASE_DB) &&
                   lcnt < LCNT_MAX) begin
        lcnt_n = lcnt + LCNT_W'(1);
        long_c = (lcnt == LCNT_LAST);
      end
    end

    assign long_d[g] = long_c;
  end

  always_ff @(posedge clk) begin
    if (!rst) long <= '0;
    else      long <= long_d;
  end
`else
  assign long = '0;
`endif

endmodule

// File: tb/tb_key_filter_multi.sv
// Randomised and directed bench for key_filter_multi with a scoreboard fed by a debounce reference model.
module tb_key_filter_multi;

  localparam int unsigned N  = 4;
  localparam int unsigned MAX = 8;
  localparam int unsigned CW = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [N-1:0]  in  = '1;
  logic [N-1:0]  press;
  logic [N-1:0]  rel;
  logic [N-1:0]  level;
  logic [N-1:0]  long;
  logic          valid;
  logic [CW-1:0] code;

  key_filter_multi #(
    .N(N), .MAX(MAX), .CNT_W(20), .LONG(20), .LCNT_W(24), .CODE_W(CW)
  ) dut (
    .clk(clk), .rst(rst), .in(in), .press(press), .rel(rel),
    .level(level), .long(long), .valid(valid), .code(code)
  );

  always #5 clk = ~clk;

  typedef struct {
    int            cyc;
    logic [N-1:0]  press;
    logic [N-1:0]  rel;
    logic [N-1:0]  level;
    logic [CW-1:0] code;
  } ev_t;

  ev_t q[$];
  int  tests = 0;
  int  fails = 0;
  int  m_cyc = 0;
  logic [N-1:0] long_or = '0;

  // Reference: raw input seen two clocks late; a debounced level flips after
  // MAX+1 consecutive samples that disagree with it.
  logic [N-1:0] m_hist0 = '1;
  logic [N-1:0] m_hist1 = '1;
  logic [N-1:0] m_level = '0;
  int           run [N];
  logic [N-1:0] m_p;
  logic [N-1:0] m_r;
  ev_t          m_e;

  always @(posedge clk) begin
    m_cyc++;
    m_p = '0;
    m_r = '0;
    if (!rst) begin
      m_hist0 = '1;
      m_hist1 = '1;
      m_level = '0;
      for (int i = 0; i < N; i++) run[i] = 0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if ((!m_hist1[i]) != m_level[i]) run[i]++;
        else run[i] = 0;
        if (run[i] == MAX + 1) begin
          run[i] = 0;
          if (m_level[i]) m_r[i] = 1'b1;
          else m_p[i] = 1'b1;
          m_level[i] = ~m_level[i];
        end
      end
      m_hist1 = m_hist0;
      m_hist0 = in;
    end
    if ((m_p | m_r) != '0) begin
      m_e.cyc   = m_cyc;
      m_e.press = m_p;
      m_e.rel   = m_r;
      m_e.level = m_level;
      m_e.code  = '0;
      for (int i = N - 1; i >= 0; i--) if (m_p[i]) m_e.code = CW'(i);
      q.push_back(m_e);
    end
  end

  ev_t mon_e;

  // Monitor: every output event must match the next expected event, cycle-exact.
  always @(negedge clk) begin
    long_or = long_or | long;
    if ((press | rel) != '0 || valid !== 1'b0 || code !== '0) begin
      tests++;
      if (q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_event cyc=%0d press=%b rel=%b valid=%b code=%0d", m_cyc, press, rel, valid, code);
      end else begin
        mon_e = q.pop_front();
        if (mon_e.cyc != m_cyc || press !== mon_e.press || rel !== mon_e.rel ||
            level !== mon_e.level || code !== mon_e.code || valid !== (mon_e.press != '0)) begin
          fails++;
          $display("FAIL event cyc=%0d press=%b rel=%b level=%b valid=%b code=%0d, want cyc=%0d press=%b rel=%b level=%b code=%0d",
                   m_cyc, press, rel, level, valid, code, mon_e.cyc, mon_e.press, mon_e.rel, mon_e.level, mon_e.code);
        end
      end
    end else if (q.size() != 0 && q[0].cyc <= m_cyc) begin
      tests++;
      fails++;
      mon_e = q.pop_front();
      $display("FAIL missed_event cyc=%0d got press=%b rel=%b, want press=%b rel=%b", m_cyc, press, rel, mon_e.press, mon_e.rel);
    end
  end

  // Waits (bounded) for the first pulse after an input change driven just before, checks latency and payload.
  task automatic wait_evt(input bit is_rel, input logic [N-1:0] mask, input int exp_lat,
                          input logic [CW-1:0] exp_code, input string name);
    int lat;
    logic [N-1:0] seen;
    lat  = -1;
    seen = '0;
    for (int k = 0; k < 40 && lat < 0; k++) begin
      @(negedge clk);
      seen = is_rel ? rel : press;
      if (seen != '0) lat = k;
    end
    tests++;
    if (lat != exp_lat || seen !== mask || valid !== !is_rel || code !== (is_rel ? '0 : exp_code)) begin
      fails++;
      $display("FAIL %s lat=%0d pulse=%b valid=%b code=%0d, want lat=%0d pulse=%b valid=%b code=%0d",
               name, lat, seen, valid, code, exp_lat, mask, !is_rel, exp_code);
    end
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  task automatic settle(input int n);
    @(negedge clk);
    in = '1;
    repeat (n) @(negedge clk);
  endtask

  int npress;

  initial begin
    // Reset, then idle keys produce nothing.
    rst = 1'b0;
    in  = '1;
    repeat (3) @(negedge clk);
    check("reset_outputs", 32'({press, rel, level, long, valid, code}), 32'd0);
    rst = 1'b1;
    repeat (100) @(negedge clk);
    check("idle_level", 32'(level), 32'd0);

    // Single press and release latency.
    in[1] = 1'b0;
    wait_evt(1'b0, 4'b0010, MAX + 2, 5'd1, "press_ch1");
    check("level_ch1_held", 32'(level), 32'h2);
    @(negedge clk);
    in[1] = 1'b1;
    wait_evt(1'b1, 4'b0010, MAX + 2, 5'd0, "release_ch1");
    check("level_ch1_rel", 32'(level), 32'h0);
    settle(15);

    // Bounce shorter than the debounce window is rejected.
    in[0] = 1'b0; repeat (5) @(negedge clk);
    in[0] = 1'b1; repeat (2) @(negedge clk);
    in[0] = 1'b0; repeat (5) @(negedge clk);
    in[0] = 1'b1; repeat (15) @(negedge clk);
    check("bounce_level", 32'(level), 32'h0);
    in[0] = 1'b0;
    npress = 0;
    repeat (25) begin
      @(negedge clk);
      if (press[0]) npress++;
    end
    check("hold_one_press", 32'(npress), 32'd1);
    settle(15);

    // Simultaneous presses: code reports the lowest channel.
    in[3] = 1'b0;
    in[2] = 1'b0;
    wait_evt(1'b0, 4'b1100, MAX + 2, 5'd2, "press_ch3_ch2");
    settle(15);

    // Reset in the middle of a debounce aborts it; held key re-presses after reset.
    in[0] = 1'b0;
    repeat (8) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_mid_level", 32'(level), 32'h0);
    rst = 1'b1;
    wait_evt(1'b0, 4'b0001, MAX + 2, 5'd0, "press_after_reset");
    settle(15);

`ifdef KEY_LONG_PRESS_EN
    begin
      int llat;
      in[2] = 1'b0;
      wait_evt(1'b0, 4'b0100, MAX + 2, 5'd2, "press_long");
      llat = -1;
      for (int k = 1; k < 60 && llat < 0; k++) begin
        @(negedge clk);
        if (long[2]) llat = k;
      end
      check("long_latency", 32'(llat), 32'd20);
      settle(15);
      long_or = '0;
      in[2] = 1'b0;
      repeat (15) @(negedge clk);
      in[2] = 1'b1;
      repeat (30) @(negedge clk);
      check("short_hold_no_long", 32'(long_or), 32'h0);
    end
`endif

    // Random key activity with runs both shorter and longer than the window.
    repeat (3000) begin
      @(negedge clk);
      for (int i = 0; i < N; i++) if ($urandom_range(0, 11) == 0) in[i] = ~in[i];
    end
    settle(30);

    check("queue_drained", 32'(q.size()), 32'd0);
`ifndef KEY_LONG_PRESS_EN
    check("long_tied_low", 32'(long_or), 32'h0);
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
